// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM states and redirect kinds.
// Redirect kind codes double as priorities, so a larger code always wins.
package pc_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    BRANCH = 3'd1,
    JUMP   = 3'd2,
    ERET   = 3'd3,
    IRQ    = 3'd4
  } kind_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch handshake, redirect requests and interrupt status between the
// sequencer (master) and the rest of the core (slave).
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             en;
  logic             stall;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             branch_req;
  logic [WIDTH-1:0] branch_target;
  logic             jump_req;
  logic [WIDTH-1:0] jump_target;
  logic             irq_req;
  logic             eret_req;
  logic             irq_ack;
  logic [WIDTH-1:0] epc;
  logic             in_isr;

  modport master (
    input  en, stall, fetch_ready,
    input  branch_req, branch_target, jump_req, jump_target,
    input  irq_req, eret_req,
    output pc, pc_valid, irq_ack, epc, in_isr
  );

  modport slave (
    output en, stall, fetch_ready,
    output branch_req, branch_target, jump_req, jump_target,
    output irq_req, eret_req,
    input  pc, pc_valid, irq_ack, epc, in_isr
  );
endinterface

// File: rtl/pc_sequencer_pc_reg.sv
// Loadable PC register; asynchronous active-low reset to RESET_VEC.
module pc_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= RESET_VEC;
    end else if (ld_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Owns the PC: presents it to fetch, advances it sequentially and applies
// prioritised redirects, buffering one redirect while the PC cannot advance.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] IRQ_VEC   = 32'h0000_4180
) (
  input  logic             CLK,
  input  logic             RST_n,
  pc_sequencer_if.master   bus_io
);

  state_e           state_q, state_d;
  kind_e            pend_kind_q, pend_kind_d;
  logic [WIDTH-1:0] pend_dat_q, pend_dat_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             isr_q, isr_d;
  logic             ack_q, ack_d;

  logic [WIDTH-1:0] pc_cur, pc_inc, pc_nxt;
  logic             advance;
  kind_e            live_kind, win_kind;
  logic [WIDTH-1:0] live_tgt, win_dat;
  logic             use_live;

  assign pc_inc  = pc_cur + WIDTH'(STEP);
  assign advance = (state_q == RUN) && bus_io.fetch_ready && !bus_io.stall;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus_io.en)  state_d = RUN;
      RUN:     if (!bus_io.en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Later assignments override earlier ones, so this encodes the priority order.
  always_comb begin
    live_kind = NONE;
    live_tgt  = '0;
    if (bus_io.branch_req) begin
      live_kind = BRANCH;
      live_tgt  = bus_io.branch_target;
    end
    if (bus_io.jump_req) begin
      live_kind = JUMP;
      live_tgt  = bus_io.jump_target;
    end
    if (bus_io.eret_req && isr_q) begin
      live_kind = ERET;
      live_tgt  = epc_q;
    end
    if (bus_io.irq_req && !isr_q) begin
      live_kind = IRQ;
      live_tgt  = IRQ_VEC;
    end
  end

  // On a tie the live request wins; a pending IRQ keeps its return PC in pend_dat.
  assign use_live = (live_kind != NONE) && (live_kind >= pend_kind_q);
  assign win_kind = use_live ? live_kind : pend_kind_q;
  assign win_dat  = use_live ? live_tgt  : pend_dat_q;

  always_comb begin
    pc_nxt      = pc_inc;
    pend_kind_d = pend_kind_q;
    pend_dat_d  = pend_dat_q;
    epc_d       = epc_q;
    isr_d       = isr_q;
    ack_d       = 1'b0;
    if (advance) begin
      pend_kind_d = NONE;
      case (win_kind)
        IRQ: begin
          pc_nxt = IRQ_VEC;
          epc_d  = use_live ? pc_inc : pend_dat_q;
          isr_d  = 1'b1;
          ack_d  = 1'b1;
        end
        ERET: begin
          pc_nxt = epc_q;
          isr_d  = 1'b0;
        end
        JUMP, BRANCH: pc_nxt = win_dat;
        default:      pc_nxt = pc_inc;
      endcase
    end else if (live_kind > pend_kind_q) begin
      pend_kind_d = live_kind;
      pend_dat_d  = (live_kind == IRQ) ? pc_inc : live_tgt;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      pend_kind_q <= NONE;
      pend_dat_q  <= '0;
      epc_q       <= '0;
      isr_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_kind_q <= pend_kind_d;
      pend_dat_q  <= pend_dat_d;
      epc_q       <= epc_d;
      isr_q       <= isr_d;
      ack_q       <= ack_d;
    end
  end

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_VEC(RESET_VEC)
  ) u_pc_reg (
    .clk_i (CLK),
    .rst_ni(RST_n),
    .ld_i  (advance),
    .d_i   (pc_nxt),
    .q_o   (pc_cur)
  );

  assign bus_io.pc       = pc_cur;
  assign bus_io.pc_valid = (state_q == RUN);
  assign bus_io.irq_ack  = ack_q;
  assign bus_io.epc      = epc_q;
  assign bus_io.in_isr   = isr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_3000;
  localparam logic [31:0] IV = 32'h0000_4180;

  logic CLK   = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  pc_sequencer_if #(.WIDTH(32)) bus();

  pc_sequencer #(
    .WIDTH(32), .RESET_VEC(RV), .STEP(4), .IRQ_VEC(IV)
  ) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus_io(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  // Model: running flag, pc, epc, isr, ack, and pending slot (priority, target, return pc).
  bit          m_run, m_isr, m_ack;
  logic [31:0] m_pc, m_epc, m_pt, m_pe;
  int          m_pk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_isr = 0; m_ack = 0;
    m_pc = RV; m_epc = 0; m_pk = 0; m_pt = 0; m_pe = 0;
  endfunction

  function automatic void model_step();
    bit          adv, ack_n;
    int          lk, k;
    logic [31:0] lt, inc, t, e;
    adv   = m_run && bus.fetch_ready && !bus.stall;
    inc   = m_pc + 32'd4;
    lk    = 0;
    lt    = 0;
    ack_n = 0;
    if (bus.branch_req)         begin lk = 1; lt = bus.branch_target; end
    if (bus.jump_req)           begin lk = 2; lt = bus.jump_target;   end
    if (bus.eret_req && m_isr)  begin lk = 3; lt = m_epc;             end
    if (bus.irq_req && !m_isr)  begin lk = 4; lt = IV;                end
    if (adv) begin
      if (lk > 0 && lk >= m_pk) begin k = lk;   t = lt;   e = inc;  end
      else                      begin k = m_pk; t = m_pt; e = m_pe; end
      case (k)
        4: begin m_epc = e; m_pc = IV; m_isr = 1; ack_n = 1; end
        3: begin m_pc = m_epc; m_isr = 0; end
        0: m_pc = inc;
        default: m_pc = t;
      endcase
      m_pk = 0;
    end else if (lk > m_pk) begin
      m_pk = lk; m_pt = lt; m_pe = inc;
    end
    m_ack = ack_n;
    m_run = bus.en;
  endfunction

  always @(negedge CLK) begin
    if (chk_on) begin
      cmp("pc",       bus.pc,              m_pc);
      cmp("pc_valid", 32'(bus.pc_valid),   32'(m_run));
      cmp("irq_ack",  32'(bus.irq_ack),    32'(m_ack));
      cmp("epc",      bus.epc,             m_epc);
      cmp("in_isr",   32'(bus.in_isr),     32'(m_isr));
    end
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic clear_reqs();
    bus.branch_req = 0; bus.jump_req = 0; bus.irq_req = 0; bus.eret_req = 0;
  endtask

  task automatic async_reset();
    #2;
    RST_n = 1'b0;
    model_reset();
    #1;
    cmp("rst_pc",     bus.pc,            RV);
    cmp("rst_valid",  32'(bus.pc_valid), 32'd0);
    cmp("rst_isr",    32'(bus.in_isr),   32'd0);
    cmp("rst_epc",    bus.epc,           32'd0);
    #3;
    RST_n = 1'b1;
  endtask

  initial begin
    bus.en = 0; bus.stall = 0; bus.fetch_ready = 0;
    bus.branch_target = 0; bus.jump_target = 0;
    clear_reqs();
    model_reset();
    #12;
    RST_n  = 1'b1;
    chk_on = 1'b1;

    // Boot
    tick(); tick();
    cmp("boot_idle_pc", bus.pc, 32'h3000);
    cmp("boot_idle_valid", 32'(bus.pc_valid), 32'd0);
    bus.en = 1; bus.fetch_ready = 1;
    tick(); cmp("boot_pc0", bus.pc, 32'h3000); cmp("boot_valid", 32'(bus.pc_valid), 32'd1);
    tick(); cmp("boot_pc1", bus.pc, 32'h3004);
    tick(); cmp("boot_pc2", bus.pc, 32'h3008);

    // Stall with buffered branch
    bus.stall = 1; tick();
    bus.branch_req = 1; bus.branch_target = 32'h3100; tick();
    clear_reqs(); tick();
    cmp("stall_hold", bus.pc, 32'h3008);
    bus.stall = 0; tick();
    cmp("stall_branch", bus.pc, 32'h3100);

    // Priority: live tie-break and live beats lower pending
    bus.jump_req = 1; bus.jump_target = 32'h3200;
    bus.branch_req = 1; bus.branch_target = 32'h3100; tick();
    cmp("prio_a", bus.pc, 32'h3200);
    clear_reqs(); bus.stall = 1; bus.branch_req = 1; tick();
    clear_reqs(); bus.stall = 0; bus.jump_req = 1; bus.jump_target = 32'h3300; tick();
    cmp("prio_b", bus.pc, 32'h3300);

    // Interrupt round trip
    bus.jump_target = 32'h3010; tick(); clear_reqs();
    bus.irq_req = 1; tick();
    cmp("irq_pc", bus.pc, 32'h4180); cmp("irq_epc", bus.epc, 32'h3014);
    cmp("irq_isr", 32'(bus.in_isr), 32'd1); cmp("irq_ack1", 32'(bus.irq_ack), 32'd1);
    bus.irq_req = 0; tick();
    cmp("irq_ack0", 32'(bus.irq_ack), 32'd0); cmp("isr_pc", bus.pc, 32'h4184);
    bus.irq_req = 1; tick();
    cmp("irq2_masked", bus.pc, 32'h4188); cmp("irq2_epc", bus.epc, 32'h3014);
    bus.irq_req = 0; bus.eret_req = 1; tick();
    cmp("eret_pc", bus.pc, 32'h3014); cmp("eret_isr", 32'(bus.in_isr), 32'd0);
    tick();
    cmp("eret2_ignored", bus.pc, 32'h3018);
    clear_reqs();

    // Wrap and enable gap
    bus.jump_req = 1; bus.jump_target = 32'hFFFF_FFFC; tick(); clear_reqs();
    bus.en = 0; tick();
    cmp("wrap_pc", bus.pc, 32'h0); cmp("gap_valid", 32'(bus.pc_valid), 32'd0);
    bus.jump_req = 1; bus.jump_target = 32'h3400; tick(); clear_reqs();
    cmp("gap_hold", bus.pc, 32'h0);
    bus.en = 1; tick();
    cmp("resume_pc", bus.pc, 32'h0); cmp("resume_valid", 32'(bus.pc_valid), 32'd1);
    tick();
    cmp("resume_jump", bus.pc, 32'h3400);

    // Async reset with a pending branch and handler active
    bus.irq_req = 1; tick(); clear_reqs();
    bus.stall = 1; bus.branch_req = 1; bus.branch_target = 32'h3100; tick(); clear_reqs();
    tick();
    async_reset();
    bus.stall = 0; bus.en = 0; tick();
    bus.en = 1; tick(); tick();
    cmp("post_rst_pc", bus.pc, 32'h3004);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      bus.en          = ($urandom_range(0, 15) != 0);
      bus.stall       = ($urandom_range(0, 3) == 0);
      bus.fetch_ready = ($urandom_range(0, 4) != 0);
      bus.branch_req  = ($urandom_range(0, 5) == 0);
      bus.jump_req    = ($urandom_range(0, 7) == 0);
      bus.irq_req     = ($urandom_range(0, 9) == 0);
      bus.eret_req    = ($urandom_range(0, 5) == 0);
      bus.branch_target = $urandom();
      bus.jump_target   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      if ($urandom_range(0, 599) == 0) async_reset();
      tick();
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
